// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
//
// Purpose:
//   ID stage of a classic 5-stage MIPS-style pipeline. Holds the IF/ID
//   pipeline register, the 32x32 register file (with write-to-read bypass from
//   writeback), the immediate sign extender, jump-target formation and the
//   main control decoder.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          asynchronous active-low reset
//   i_instruction    fetched instruction from IF
//   i_pc_increment   PC+4 from IF
//   i_stall          hold the IF/ID register
//   i_flush          replace the IF/ID contents with a bubble (beats stall)
//   i_wb_en/addr/data  register-file write port from WB
//   o_rs_data/o_rt_data  register read data (bypassed from WB)
//   o_imm_ext        sign-extended instr[15:0]
//   o_rs/o_rt/o_rd   register specifier fields
//   o_pc_increment   registered PC+4
//   o_jump_address   {pc_increment[31:28], instr[25:0], 2'b00}
//   o_branch .. o_reg_dst, o_alu_op   decoded control, zero for bubbles
//   o_valid          IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module instruction_decode_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc_increment,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_rs_data,
  output logic [31:0] o_rt_data,
  output logic [31:0] o_imm_ext,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [31:0] o_pc_increment,
  output logic [31:0] o_jump_address,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_mem_to_reg,
  output logic        o_alu_src,
  output logic        o_reg_dst,
  output logic [1:0]  o_alu_op,
  output logic        o_valid
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] instr;
  logic [31:0] pc_increment;
  logic        valid;
  logic [31:0] regs [32];

  // Reset is level-sensitive on the outputs too, so the stage reads as all
  // zeros the instant reset drops, even if NOP_WORD is not zero.
  logic in_reset;
  assign in_reset = ~i_reset;

  // IF/ID pipeline register: flush beats stall beats load.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      instr        <= NOP_WORD;
      pc_increment <= 32'h0;
      valid        <= 1'b0;
    end else if (i_flush) begin
      instr        <= NOP_WORD;
      pc_increment <= 32'h0;
      valid        <= 1'b0;
    end else if (!i_stall) begin
      instr        <= i_instruction;
      pc_increment <= i_pc_increment;
      valid        <= 1'b1;
    end
  end

  // Register file. Writes are independent of stall so writeback is never lost
  // while decode is held; r0 is never written. Async reset aborts any write
  // in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  // Combinational reads with same-cycle bypass of the value being written
  // back, so a dependent instruction sitting in ID sees it without a stall.
  always_comb begin
    o_rs_data = 32'h0;
    o_rt_data = 32'h0;
    if (!in_reset) begin
      if (rs != 5'd0) begin
        o_rs_data = (i_wb_en && (i_wb_addr == rs)) ? i_wb_data : regs[rs];
      end
      if (rt != 5'd0) begin
        o_rt_data = (i_wb_en && (i_wb_addr == rt)) ? i_wb_data : regs[rt];
      end
    end
  end

  assign o_imm_ext      = in_reset ? 32'h0 : {{16{instr[15]}}, instr[15:0]};
  assign o_rs           = in_reset ? 5'd0 : rs;
  assign o_rt           = in_reset ? 5'd0 : rt;
  assign o_rd           = in_reset ? 5'd0 : rd;
  assign o_pc_increment = pc_increment;
  assign o_jump_address = in_reset ? 32'h0 : {pc_increment[31:28], instr[25:0], 2'b00};
  assign o_valid        = valid;

  // Main control decoder. Bubbles (valid=0) and unknown opcodes decode to all
  // zeros so nothing downstream has a side effect.
  always_comb begin
    o_reg_dst    = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_alu_op     = 2'b00;
    if (valid && !in_reset) begin
      unique case (instr[31:26])
        OP_RTYPE: begin
          o_reg_dst   = 1'b1;
          o_reg_write = 1'b1;
          o_alu_op    = 2'b10;
        end
        OP_LW: begin
          o_alu_src    = 1'b1;
          o_mem_to_reg = 1'b1;
          o_reg_write  = 1'b1;
          o_mem_read   = 1'b1;
        end
        OP_SW: begin
          o_alu_src   = 1'b1;
          o_mem_write = 1'b1;
        end
        OP_BEQ: begin
          o_branch = 1'b1;
          o_alu_op = 2'b01;
        end
        OP_ADDI: begin
          o_alu_src   = 1'b1;
          o_reg_write = 1'b1;
        end
        OP_J: begin
          o_jump = 1'b1;
        end
        default: begin
          o_reg_dst = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameter NOP_WORD, default 32'h0000_0000: the instruction word loaded into IF/ID on flush and on reset.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 i_clk  input  1  the single clock; rising edge active.
REQ-004 i_reset  input  1  asynchronous active-low reset.
REQ-005 i_instruction  input  32  fetched instruction from IF.
REQ-006 i_pc_increment  input  32  PC+4 from IF.
REQ-007 i_stall  input  1  hold the IF/ID register.
REQ-008 i_flush  input  1  replace the IF/ID contents with a bubble.
REQ-009 i_wb_en, i_wb_addr, i_wb_data  input  1/5/32  writeback port from WB.
REQ-010 o_rs_data, o_rt_data  output  32  register-file read data.
REQ-011 o_imm_ext  output  32  sign-extended instr[15:0].
REQ-012 o_rs, o_rt, o_rd  output  5  instr[25:21], instr[20:16], instr[15:11].
REQ-013 o_pc_increment  output  32  registered PC+4.
REQ-014 o_jump_address  output  32  {o_pc_increment[31:28], instr[25:0], 2'b00}.
REQ-015 o_branch, o_jump, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst  output  1 each  control signals.
REQ-016 o_alu_op  output  2  ALU operation class.
REQ-017 o_valid  output  1  the IF/ID register holds a real instruction.

Function
REQ-018 The IF/ID register (instr, pc_increment, valid) shall update on the rising edge with priority flush > stall > load.
REQ-019 Flush: instr=NOP_WORD, pc_increment=0, valid=0.
REQ-020 Stall without flush: all IF/ID fields hold their values.
REQ-021 Load: instr=i_instruction, pc_increment=i_pc_increment, valid=1.
REQ-022 Register file: 32x32; a write shall occur on the rising edge when i_wb_en=1 and i_wb_addr!=0; i_wb_addr=0 is never written.
REQ-023 Register reads shall be combinational; register 0 shall read as 0.
REQ-024 Read-during-write bypass: when i_wb_en=1 and i_wb_addr==rs!=0, o_rs_data=i_wb_data in the same cycle; the same rule applies to rt.
REQ-025 Decode by opcode instr[31:26], giving (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op):
- 000000 R-type: 1,0,0,1,0,0,0,0,10
- 100011 lw: 0,1,1,1,1,0,0,0,00
- 101011 sw: 0,1,0,0,0,1,0,0,00
- 000100 beq: 0,0,0,0,0,0,1,0,01
- 001000 addi: 0,1,0,1,0,0,0,0,00
- 000010 j: 0,0,0,0,0,0,0,1,00
REQ-026 Any other opcode shall drive all control outputs to 0.
REQ-027 All control outputs shall be forced to 0 when valid=0.
REQ-028 A NOP_WORD of all zeros (sll $0) may assert reg_write only with rd=0, so it has no architectural effect.
REQ-029 Simultaneous i_stall and writeback: the register-file write shall proceed and the held instruction shall see the bypassed data.

Reset
REQ-030 While i_reset=0, asynchronously: IF/ID instr=NOP_WORD, pc_increment=0, valid=0, and all 32 registers=0.
REQ-031 During reset all control outputs shall be 0, and o_rs_data, o_rt_data and o_imm_ext shall be 0.
REQ-032 Reset asserted mid-stall or mid-write shall take priority and abort the pending write.

Verification
REQ-033 Write 0xDEAD_BEEF to r5, then load instr 0x00A6_3820 (add r7,r5,r6) -> o_rs_data=0xDEAD_BEEF, o_reg_dst=1, o_reg_write=1, o_alu_op=10.
REQ-034 Write 0x1234 to r0, then read rs=0 -> o_rs_data=0.
REQ-035 Same cycle: wb to r9 with 0x55 and IF/ID holds instr with rt=9 -> o_rt_data=0x55.
REQ-036 Load lw 0x8D28_FFFC, then assert i_stall for 3 cycles -> o_imm_ext=0xFFFF_FFFC for all 3 cycles, o_mem_read=1.
REQ-037 Load j 0x0800_0010 with PC+4=0x4000_0004 -> o_jump=1, o_jump_address=0x4000_0040; then i_flush=1 and i_stall=1 -> next cycle o_valid=0 and all controls 0.
REQ-038 Drop i_reset asynchronously between clock edges -> all outputs are 0 immediately, and a register read after reset release returns 0.
